clint_arbiter: RTL and testbench

CLINT_ARBITER -- requirements
Module: clint_arbiter

---
 rtl/clint_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_clint_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_arbiter.sv
// Two-master arbiter in front of the CLINT timer slave.
// One transaction (write or read) owns the slave at a time. Masters are
// granted round-robin, with at least one idle cycle between transactions.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 64
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module clint_arbiter #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (core LSU)
  input  logic [ADDR_WIDTH-1:0] s0_awaddr,
  input  logic                  s0_awvaild,
  output logic                  s0_awready,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic                  s0_wvaild,
  output logic                  s0_wready,
  output logic                  s0_bvaild,
  input  logic                  s0_bready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic                  s0_arvaild,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rvaild,
  input  logic                  s0_rready,
  // master 1 (debug)
  input  logic [ADDR_WIDTH-1:0] s1_awaddr,
  input  logic                  s1_awvaild,
  output logic                  s1_awready,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic                  s1_wvaild,
  output logic                  s1_wready,
  output logic                  s1_bvaild,
  input  logic                  s1_bready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic                  s1_arvaild,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rvaild,
  input  logic                  s1_rready,
  // timer slave
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvaild,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvaild,
  input  logic                  m_wready,
  input  logic                  m_bvaild,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvaild,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvaild,
  output logic                  m_rready,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic       rr_ptr, rr_ptr_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  logic       ar_done, ar_done_nxt;

  logic       sel;
  logic       req0, req1, win;
  logic       sel_awvaild, sel_wvaild, sel_bready, sel_arvaild, sel_rready;
  logic       awready_g, wready_g, bvaild_g, arready_g, rvaild_g;

  // sel = 1 means master 1 owns the slave; only meaningful outside IDLE
  assign sel         = grant[1];
  assign sel_awvaild = sel ? s1_awvaild : s0_awvaild;
  assign sel_wvaild  = sel ? s1_wvaild  : s0_wvaild;
  assign sel_bready  = sel ? s1_bready  : s0_bready;
  assign sel_arvaild = sel ? s1_arvaild : s0_arvaild;
  assign sel_rready  = sel ? s1_rready  : s0_rready;

  assign m_awaddr = sel ? s1_awaddr : s0_awaddr;
  assign m_wdata  = sel ? s1_wdata  : s0_wdata;
  assign m_araddr = sel ? s1_araddr : s0_araddr;

  // read data is not qualified; rvaild tells each master whether it is theirs
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign grant_o  = grant;

  // channel responses reach only the granted master
  assign s0_awready = awready_g & grant[0];
  assign s0_wready  = wready_g  & grant[0];
  assign s0_bvaild  = bvaild_g  & grant[0];
  assign s0_arready = arready_g & grant[0];
  assign s0_rvaild  = rvaild_g  & grant[0];
  assign s1_awready = awready_g & grant[1];
  assign s1_wready  = wready_g  & grant[1];
  assign s1_bvaild  = bvaild_g  & grant[1];
  assign s1_arready = arready_g & grant[1];
  assign s1_rvaild  = rvaild_g  & grant[1];

  // next-state, arbitration and slave-side forwarding
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    ar_done_nxt = ar_done;
    req0        = s0_awvaild | s0_wvaild | s0_arvaild;
    req1        = s1_awvaild | s1_wvaild | s1_arvaild;
    win         = (req0 & req1) ? rr_ptr : req1;
    m_awvaild   = 1'b0;
    m_wvaild    = 1'b0;
    m_bready    = 1'b0;
    m_arvaild   = 1'b0;
    m_rready    = 1'b0;
    awready_g   = 1'b0;
    wready_g    = 1'b0;
    bvaild_g    = 1'b0;
    arready_g   = 1'b0;
    rvaild_g    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_nxt   = win ? 2'b10 : 2'b01;
          // a write from the winner takes priority over its own read
          state_nxt   = (win ? (s1_awvaild | s1_wvaild) : (s0_awvaild | s0_wvaild)) ? WRITE : READ;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          ar_done_nxt = 1'b0;
        end
      end
      WRITE: begin
        m_awvaild = sel_awvaild & ~aw_done;
        m_wvaild  = sel_wvaild & ~w_done;
        m_bready  = sel_bready;
        awready_g = m_awready & ~aw_done;
        wready_g  = m_wready & ~w_done;
        bvaild_g  = m_bvaild;
        if (sel_awvaild && !aw_done && m_awready) aw_done_nxt = 1'b1;
        if (sel_wvaild && !w_done && m_wready)    w_done_nxt  = 1'b1;
        if (m_bvaild && sel_bready) begin
          state_nxt   = IDLE;
          grant_nxt   = 2'b00;
          rr_ptr_nxt  = ~sel;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      READ: begin
        m_arvaild = sel_arvaild & ~ar_done;
        m_rready  = sel_rready;
        arready_g = m_arready & ~ar_done;
        rvaild_g  = m_rvaild;
        if (sel_arvaild && !ar_done && m_arready) ar_done_nxt = 1'b1;
        if (m_rvaild && sel_rready) begin
          state_nxt   = IDLE;
          grant_nxt   = 2'b00;
          rr_ptr_nxt  = ~sel;
          ar_done_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // state, grant, round-robin pointer and handshake-done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 2'b00;
      rr_ptr  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      ar_done <= ar_done_nxt;
    end
  end

endmodule

// File: tb/tb_clint_arbiter.sv
// Bench for clint_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a transaction model.
module tb_clint_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [AW-1:0] MTIMECMP = 64'h0000_0000_0200_4000;
  localparam logic [AW-1:0] MTIME    = 64'h0000_0000_0200_BFF8;
  localparam logic [DW-1:0] MTIME_V  = 64'h0000_1234_5678_9ABC;

  logic clk, rst;
  logic [AW-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
  logic [DW-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, m_wdata, m_rdata;
  logic s0_awvaild, s0_awready, s0_wvaild, s0_wready, s0_bvaild, s0_bready;
  logic s0_arvaild, s0_arready, s0_rvaild, s0_rready;
  logic s1_awvaild, s1_awready, s1_wvaild, s1_wready, s1_bvaild, s1_bready;
  logic s1_arvaild, s1_arready, s1_rvaild, s1_rready;
  logic m_awvaild, m_awready, m_wvaild, m_wready, m_bvaild, m_bready;
  logic m_arvaild, m_arready, m_rvaild, m_rready;
  logic [1:0] grant_o;

  int checks, failures;
  int hs_aw, hs_w;

  // transaction-level model: who owns the slave, what kind, what was accepted
  int own, rr;
  bit own_wr, maw_d, mw_d, mar_d, mdl_ok;

  logic [16:0] ctl_w;
  assign ctl_w = {grant_o, m_awvaild, m_wvaild, m_bready, m_arvaild, m_rready,
                  s0_awready, s0_wready, s0_bvaild, s0_arready, s0_rvaild,
                  s1_awready, s1_wready, s1_bvaild, s1_arready, s1_rvaild};

  clint_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_awaddr(s0_awaddr), .s0_awvaild(s0_awvaild), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wvaild(s0_wvaild), .s0_wready(s0_wready),
    .s0_bvaild(s0_bvaild), .s0_bready(s0_bready),
    .s0_araddr(s0_araddr), .s0_arvaild(s0_arvaild), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvaild(s0_rvaild), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awvaild(s1_awvaild), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wvaild(s1_wvaild), .s1_wready(s1_wready),
    .s1_bvaild(s1_bvaild), .s1_bready(s1_bready),
    .s1_araddr(s1_araddr), .s1_arvaild(s1_arvaild), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvaild(s1_rvaild), .s1_rready(s1_rready),
    .m_awaddr(m_awaddr), .m_awvaild(m_awvaild), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvaild(m_wvaild), .m_wready(m_wready),
    .m_bvaild(m_bvaild), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvaild(m_arvaild), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvaild(m_rvaild), .m_rready(m_rready),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // compare DUT against the model for the current cycle, then advance the
  // model by what the coming clock edge will sample
  task automatic model_step();
    logic [1:0] awv, wv, arv, bv, rv, req;
    logic [1:0] eg, eawr, ewr, eb, earr, erv;
    logic emaw, emw, emb, emar, emr;
    logic [16:0] ectl;
    awv = {s1_awvaild, s0_awvaild};
    wv  = {s1_wvaild, s0_wvaild};
    arv = {s1_arvaild, s0_arvaild};
    bv  = {s1_bready, s0_bready};
    rv  = {s1_rready, s0_rready};
    eg = '0; eawr = '0; ewr = '0; eb = '0; earr = '0; erv = '0;
    emaw = 1'b0; emw = 1'b0; emb = 1'b0; emar = 1'b0; emr = 1'b0;
    if (mdl_ok && own >= 0) begin
      eg[own] = 1'b1;
      if (own_wr) begin
        emaw = awv[own] & ~maw_d;
        emw  = wv[own] & ~mw_d;
        emb  = bv[own];
        eawr[own] = m_awready & ~maw_d;
        ewr[own]  = m_wready & ~mw_d;
        eb[own]   = m_bvaild;
      end else begin
        emar = arv[own] & ~mar_d;
        emr  = rv[own];
        earr[own] = m_arready & ~mar_d;
        erv[own]  = m_rvaild;
      end
    end
    if (mdl_ok) begin
      ectl = {eg, emaw, emw, emb, emar, emr,
              eawr[0], ewr[0], eb[0], earr[0], erv[0],
              eawr[1], ewr[1], eb[1], earr[1], erv[1]};
      chk("ctl", 64'(ctl_w), 64'(ectl));
      chk("s1_rdata", s1_rdata, m_rdata);
      if (own >= 0 && own_wr) begin
        chk("m_awaddr", m_awaddr, (own == 1) ? s1_awaddr : s0_awaddr);
        chk("m_wdata", m_wdata, (own == 1) ? s1_wdata : s0_wdata);
      end
      if (own >= 0 && !own_wr)
        chk("m_araddr", m_araddr, (own == 1) ? s1_araddr : s0_araddr);
    end
    if (m_awvaild === 1'b1 && m_awready === 1'b1) hs_aw++;
    if (m_wvaild === 1'b1 && m_wready === 1'b1) hs_w++;
    req = {awv[1] | wv[1] | arv[1], awv[0] | wv[0] | arv[0]};
    if (rst) begin
      own = -1; rr = 0; maw_d = 0; mw_d = 0; mar_d = 0; mdl_ok = 1;
    end else if (mdl_ok) begin
      if (own < 0) begin
        if (req != 2'b00) begin
          own = (req == 2'b11) ? rr : (req[1] ? 1 : 0);
          own_wr = awv[own] | wv[own];
          maw_d = 0; mw_d = 0; mar_d = 0;
        end
      end else if (own_wr) begin
        if (m_bvaild && bv[own]) begin
          rr = 1 - own; own = -1;
        end else begin
          if (emaw && m_awready) maw_d = 1;
          if (emw && m_wready) mw_d = 1;
        end
      end else begin
        if (m_rvaild && rv[own]) begin
          rr = 1 - own; own = -1;
        end else if (emar && m_arready) mar_d = 1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    s0_awaddr = '0; s0_awvaild = 0; s0_wdata = '0; s0_wvaild = 0; s0_bready = 0;
    s0_araddr = '0; s0_arvaild = 0; s0_rready = 0;
    s1_awaddr = '0; s1_awvaild = 0; s1_wdata = '0; s1_wvaild = 0; s1_bready = 0;
    s1_araddr = '0; s1_arvaild = 0; s1_rready = 0;
    m_awready = 0; m_wready = 0; m_bvaild = 0; m_arready = 0; m_rdata = '0; m_rvaild = 0;
  endtask

  initial begin
    int base_aw, base_w;
    checks = 0; failures = 0; hs_aw = 0; hs_w = 0;
    own = -1; rr = 0; own_wr = 0; maw_d = 0; mw_d = 0; mar_d = 0; mdl_ok = 0;
    clr();
    rst = 1;
    repeat (3) adv();
    cyc(); chk("rst_grant", 64'(grant_o), 64'd0); chk("rst_ctl", 64'(ctl_w), 64'd0); adv();
    rst = 0;
    cyc(); adv();

    // master 0 writes mtimecmp alone
    s0_awaddr = MTIMECMP; s0_wdata = 64'h10; s0_awvaild = 1; s0_wvaild = 1;
    m_awready = 1; m_wready = 1;
    cyc(); chk("w0_idle_grant", 64'(grant_o), 64'd0); adv();
    cyc(); chk("w0_grant", 64'(grant_o), 64'd1); chk("w0_m_awv", 64'(m_awvaild), 64'd1);
    chk("w0_m_wv", 64'(m_wvaild), 64'd1); chk("w0_awaddr", m_awaddr, MTIMECMP);
    chk("w0_wdata", m_wdata, 64'h10); adv();
    s0_awvaild = 0; s0_wvaild = 0; m_bvaild = 1; s0_bready = 1;
    cyc(); chk("w0_bv", 64'(s0_bvaild), 64'd1); chk("w0_awv_done", 64'(m_awvaild), 64'd0); adv();
    m_bvaild = 0; s0_bready = 0;
    cyc(); chk("w0_end_grant", 64'(grant_o), 64'd0); adv();

    // master 0 write and read together: write first, read re-arbitrated
    s0_awvaild = 1; s0_wvaild = 1; s0_arvaild = 1; s0_araddr = MTIME; m_arready = 1;
    cyc(); chk("wr_idle", 64'(grant_o), 64'd0); adv();
    cyc(); chk("wr_grant", 64'(grant_o), 64'd1); chk("wr_awv", 64'(m_awvaild), 64'd1);
    chk("wr_no_arv", 64'(m_arvaild), 64'd0); adv();
    s0_awvaild = 0; s0_wvaild = 0; m_bvaild = 1; s0_bready = 1;
    cyc(); chk("wr_no_arv2", 64'(m_arvaild), 64'd0); chk("wr_no_arr", 64'(s0_arready), 64'd0);
    chk("wr_bv", 64'(s0_bvaild), 64'd1); adv();
    m_bvaild = 0; s0_bready = 0;
    cyc(); chk("wr_gap", 64'(grant_o), 64'd0); adv();
    cyc(); chk("wr_rd_grant", 64'(grant_o), 64'd1); chk("wr_rd_arv", 64'(m_arvaild), 64'd1);
    chk("wr_rd_addr", m_araddr, MTIME); adv();
    s0_arvaild = 0; m_rvaild = 1; m_rdata = MTIME_V; s0_rready = 1;
    cyc(); chk("wr_rd_rv", 64'(s0_rvaild), 64'd1); chk("wr_rd_data", s0_rdata, MTIME_V); adv();
    clr();
    cyc(); chk("wr_end", 64'(grant_o), 64'd0); adv();

    // both masters read right after reset
    rst = 1;
    cyc(); adv();
    rst = 0;
    s0_arvaild = 1; s1_arvaild = 1; s0_araddr = MTIME; s1_araddr = MTIMECMP; m_arready = 1;
    cyc(); chk("rr_idle", 64'(grant_o), 64'd0); adv();
    cyc(); chk("rr_g0", 64'(grant_o), 64'd1); chk("rr_s1_arr", 64'(s1_arready), 64'd0);
    chk("rr_addr0", m_araddr, MTIME); adv();
    s0_arvaild = 0; m_rvaild = 1; s0_rready = 1;
    cyc(); chk("rr_rv0", 64'(s0_rvaild), 64'd1); chk("rr_s1_arr2", 64'(s1_arready), 64'd0);
    chk("rr_s1_rv", 64'(s1_rvaild), 64'd0); adv();
    m_rvaild = 0; s0_rready = 0;
    cyc(); chk("rr_gap", 64'(grant_o), 64'd0); adv();
    cyc(); chk("rr_g1", 64'(grant_o), 64'd2); chk("rr_s1_arr3", 64'(s1_arready), 64'd1);
    chk("rr_addr1", m_araddr, MTIMECMP); adv();
    s1_arvaild = 0; m_rvaild = 1; s1_rready = 1;
    cyc(); chk("rr_rv1", 64'(s1_rvaild), 64'd1); adv();
    clr();
    cyc(); chk("rr_end", 64'(grant_o), 64'd0); adv();

    // slave stalls awready three cycles while accepting wdata at once
    base_aw = hs_aw; base_w = hs_w;
    s0_awvaild = 1; s0_wvaild = 1; s0_awaddr = MTIMECMP; s0_wdata = 64'h55; m_wready = 1;
    cyc(); adv();
    cyc(); chk("st_awv1", 64'(m_awvaild), 64'd1); chk("st_wv1", 64'(m_wvaild), 64'd1); adv();
    cyc(); chk("st_awv2", 64'(m_awvaild), 64'd1); chk("st_wv2", 64'(m_wvaild), 64'd0); adv();
    cyc(); chk("st_awv3", 64'(m_awvaild), 64'd1); chk("st_wv3", 64'(m_wvaild), 64'd0); adv();
    m_awready = 1;
    cyc(); chk("st_awv4", 64'(m_awvaild), 64'd1); adv();
    cyc(); chk("st_awv5", 64'(m_awvaild), 64'd0); chk("st_wv5", 64'(m_wvaild), 64'd0); adv();
    s0_awvaild = 0; s0_wvaild = 0; m_bvaild = 1; s0_bready = 1;
    cyc(); adv();
    clr();
    cyc(); chk("st_hs_aw", 64'(hs_aw - base_aw), 64'd1); chk("st_hs_w", 64'(hs_w - base_w), 64'd1);
    adv();

    // master 1 withholds rready while master 0 waits
    s1_arvaild = 1; m_arready = 1;
    cyc(); adv();
    cyc(); chk("bp_g1", 64'(grant_o), 64'd2); adv();
    s1_arvaild = 0; s0_arvaild = 1; m_rvaild = 1;
    for (int k = 0; k < 5; k++) begin
      cyc(); chk("bp_hold", 64'(grant_o), 64'd2); chk("bp_s0_arr", 64'(s0_arready), 64'd0);
      chk("bp_s1_rv", 64'(s1_rvaild), 64'd1); adv();
    end
    s1_rready = 1;
    cyc(); adv();
    m_rvaild = 0; s1_rready = 0;
    cyc(); chk("bp_gap", 64'(grant_o), 64'd0); adv();
    cyc(); chk("bp_g0", 64'(grant_o), 64'd1); adv();
    s0_arvaild = 0; m_rvaild = 1; s0_rready = 1;
    cyc(); chk("bp_rv0", 64'(s0_rvaild), 64'd1); adv();
    clr();
    cyc(); adv();

    // reset mid-read with response pending; pointer must return to master 0
    s0_arvaild = 1; m_arready = 1;
    cyc(); adv();
    cyc(); chk("ra_g0", 64'(grant_o), 64'd1); adv();
    s0_arvaild = 0; m_rvaild = 1; s0_rready = 0; rst = 1;
    cyc(); adv();
    rst = 0;
    cyc(); chk("ra_grant", 64'(grant_o), 64'd0); chk("ra_ctl", 64'(ctl_w), 64'd0); adv();
    m_rvaild = 0; s0_arvaild = 1; s1_arvaild = 1;
    cyc(); adv();
    cyc(); chk("ra_rr0", 64'(grant_o), 64'd1); adv();
    clr();
    rst = 1;
    cyc(); adv();
    rst = 0;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      s0_awvaild = ($urandom_range(0, 3) == 0);
      s0_wvaild  = ($urandom_range(0, 3) == 0);
      s0_arvaild = ($urandom_range(0, 3) == 0);
      s0_bready  = $urandom_range(0, 1) == 1;
      s0_rready  = $urandom_range(0, 1) == 1;
      s1_awvaild = ($urandom_range(0, 3) == 0);
      s1_wvaild  = ($urandom_range(0, 3) == 0);
      s1_arvaild = ($urandom_range(0, 3) == 0);
      s1_bready  = $urandom_range(0, 1) == 1;
      s1_rready  = $urandom_range(0, 1) == 1;
      m_awready  = $urandom_range(0, 1) == 1;
      m_wready   = $urandom_range(0, 1) == 1;
      m_arready  = $urandom_range(0, 1) == 1;
      m_bvaild   = ($urandom_range(0, 2) == 0);
      m_rvaild   = ($urandom_range(0, 2) == 0);
      s0_awaddr  = {$urandom, $urandom}; s1_awaddr = {$urandom, $urandom};
      s0_araddr  = {$urandom, $urandom}; s1_araddr = {$urandom, $urandom};
      s0_wdata   = {$urandom, $urandom}; s1_wdata  = {$urandom, $urandom};
      m_rdata    = {$urandom, $urandom};
      cyc(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
